exec_trace_buffer: RTL and testbench

//   Verification-side trace recorder for the 8-bit core. Detects each entry into

---
 rtl/constants_pkg.sv | 12 +
 rtl/exec_trace_buffer.sv | 134 +++++++++++++
 tb/tb_exec_trace_buffer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - shared core constants and execution stage encoding
package constants_pkg;

    typedef enum logic [2:0] {
        INSTR_FETCH  = 3'd0,
        INSTR_DECODE = 3'd1,
        EXECUTE      = 3'd2,
        MEM_ACCESS   = 3'd3,
        WRITE_BACK   = 3'd4
    } ExecutionStage;

endpackage

// File: rtl/exec_trace_buffer.sv
// rtl/exec_trace_buffer.sv - fetch-edge trace recorder with FWFT circular FIFO drain port
module exec_trace_buffer
    import constants_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  ExecutionStage            state,
    input  logic [7:0]               pc,
    input  logic [7:0]               r0,
    input  logic [7:0]               r1,
    input  logic [7:0]               r2,
    input  logic [7:0]               r3,
    input  logic [7:0]               r4,
    input  logic [7:0]               r5,
    input  logic [7:0]               r6,
    input  logic [7:0]               r7,
    input  logic                     capture_en,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [CNT_W+71:0]        trace_data,
    output logic [$clog2(DEPTH):0]   trace_count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = CNT_W + 72;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] stamp;
    logic             prev_fetch;

    logic             fetch_now;
    logic             capture;
    logic             full;
    logic             pop;
    logic             accept;
    logic             drop;
    logic [EW-1:0]    entry;

    // Edge detect on fetch entry, FIFO handshake decode and entry assembly
    always_comb begin
        fetch_now = (state == INSTR_FETCH);
        capture   = fetch_now & ~prev_fetch & capture_en;
        full      = (trace_count == FULL_CNT);
        pop       = trace_valid & trace_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        accept    = capture & (~full | pop);
        drop      = capture & full & ~pop;
        entry     = {stamp, pc, r7, r6, r5, r4, r3, r2, r1, r0};
    end

    // Head entry is presented combinationally; zero while empty so reset data reads 0
    always_comb begin
        trace_valid = (trace_count != '0);
        trace_data  = trace_valid ? mem[rd_ptr] : '0;
    end

    // Free-running cycle stamp, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stamp <= '0;
        end else begin
            stamp <= stamp + 1'b1;
        end
    end

    // Previous-cycle fetch flag so a held fetch stage yields only one capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_fetch <= 1'b0;
        end else begin
            prev_fetch <= fetch_now;
        end
    end

    // Trace storage; contents are meaningless until counted, so no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= entry;
        end
    end

    // Write pointer advances on every accepted capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Read pointer advances on every pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: push and pop in the same cycle cancel out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trace_count <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   trace_count <= trace_count + 1'b1;
                2'b01:   trace_count <= trace_count - 1'b1;
                default: trace_count <= trace_count;
            endcase
        end
    end

    // Sticky overflow and saturating drop counter, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exec_trace_buffer.sv
// tb/tb_exec_trace_buffer.sv - directed self-checking bench for exec_trace_buffer
module tb_exec_trace_buffer;
    import constants_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic                clk;
    logic                reset_n;
    ExecutionStage       state;
    logic [7:0]          pc;
    logic [7:0]          r0, r1, r2, r3, r4, r5, r6, r7;
    logic                capture_en;
    logic                trace_valid;
    logic                trace_ready;
    logic [CNT_W+71:0]   trace_data;
    logic [4:0]          trace_count;
    logic                overflow;
    logic [7:0]          drop_count;

    exec_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .state       (state),
        .pc          (pc),
        .r0          (r0),
        .r1          (r1),
        .r2          (r2),
        .r3          (r3),
        .r4          (r4),
        .r5          (r5),
        .r6          (r6),
        .r7          (r7),
        .capture_en  (capture_en),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_data  (trace_data),
        .trace_count (trace_count),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference FIFO of expected entries and bench-side cycle stamp
    logic [87:0] m_q[$];
    logic        m_prev;
    int          cyc;
    int          n_deliv;
    logic        has_last;
    logic [15:0] last_stamp;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) cyc++;
        #1;
    endtask

    // One clock: drive inputs, check any pop against the model, update the model
    task automatic step(input logic fetch, input logic en, input logic rdy,
                        input logic [7:0] pcv, input logic [7:0] rbase);
        logic cap;
        state       = fetch ? INSTR_FETCH : EXECUTE;
        capture_en  = en;
        trace_ready = rdy;
        pc = pcv;
        r0 = rbase;        r1 = rbase + 8'd1; r2 = rbase + 8'd2; r3 = rbase + 8'd3;
        r4 = rbase + 8'd4; r5 = rbase + 8'd5; r6 = rbase + 8'd6; r7 = rbase + 8'd7;
        #1;
        check_eq("valid", trace_valid, m_q.size() != 0);
        if (rdy && m_q.size() != 0) begin
            check_eq("pop_data", trace_data, m_q[0]);
            if (has_last) check_eq("stamp_inc", trace_data[87:72] > last_stamp, 1'b1);
            has_last   = 1'b1;
            last_stamp = trace_data[87:72];
            void'(m_q.pop_front());
            n_deliv++;
        end
        cap    = fetch && !m_prev && en;
        m_prev = fetch;
        if (cap && m_q.size() < DEPTH)
            m_q.push_back({cyc[15:0], pcv, r7, r6, r5, r4, r3, r2, r1, r0});
        tick();
    endtask

    task automatic edge_cap(input logic [7:0] pcv);
        step(1'b1, 1'b1, 1'b0, pcv, pcv);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && m_q.size() != 0; i++)
            step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
        check_eq("drain_done", m_q.size(), 0);
        check_eq("drain_count", trace_count, 5'd0);
    endtask

    task automatic do_reset();
        state       = EXECUTE;
        capture_en  = 1'b0;
        trace_ready = 1'b0;
        reset_n     = 1'b0;
        #2;
        check_eq("rst_valid", trace_valid, 1'b0);
        check_eq("rst_count", trace_count, 5'd0);
        check_eq("rst_ovf", overflow, 1'b0);
        check_eq("rst_drop", drop_count, 8'd0);
        check_eq("rst_data", trace_data, 88'd0);
        m_q.delete();
        m_prev   = 1'b0;
        has_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pc = 0; r0 = 0; r1 = 0; r2 = 0; r3 = 0; r4 = 0; r5 = 0; r6 = 0; r7 = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Single capture at stamp 7
        repeat (7) step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h10, 8'h01);
        check_eq("t2_valid", trace_valid, 1'b1);
        check_eq("t2_data", trace_data,
                 {16'd7, 8'h10, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
        check_eq("t2_count", trace_count, 5'd1);

        // Five entries then asynchronous reset mid-cycle
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) edge_cap(8'h20 + 8'(i));
        check_eq("t1_count5", trace_count, 5'd5);
        do_reset();

        // Fetch held 4 cycles -> one entry
        repeat (4) step(1'b1, 1'b1, 1'b0, 8'h30, 8'h30);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        check_eq("t3_held", trace_count, 5'd1);
        drain();
        // Edge with capture_en low is lost even if enable rises while held
        step(1'b1, 1'b0, 1'b0, 8'h31, 8'h31);
        step(1'b1, 1'b1, 1'b0, 8'h32, 8'h32);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        check_eq("t3_lost", trace_count, 5'd0);

        // Overflow: 17 edges with no consumer
        do_reset();
        for (int i = 1; i <= 17; i++) edge_cap(8'(i));
        check_eq("t4_count", trace_count, 5'd16);
        check_eq("t4_ovf", overflow, 1'b1);
        check_eq("t4_drop", drop_count, 8'd1);
        check_eq("t4_head_pc", trace_data[71:64], 8'd1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
        check_eq("t4_last_pc", trace_data[71:64], 8'd16);
        drain();

        // Full + pop + capture in the same cycle
        do_reset();
        for (int i = 1; i <= 16; i++) edge_cap(8'(i));
        check_eq("t5_full", trace_count, 5'd16);
        step(1'b1, 1'b1, 1'b1, 8'hA5, 8'hA5);
        check_eq("t5_count", trace_count, 5'd16);
        check_eq("t5_ovf", overflow, 1'b0);
        check_eq("t5_drop", drop_count, 8'd0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
        check_eq("t5_last_pc", trace_data[71:64], 8'hA5);
        drain();

        // Backpressure and pointer wrap: 40 edges, ready toggling each cycle
        do_reset();
        n_deliv = 0;
        for (int i = 0; i < 120; i++)
            step((i % 3) == 0, 1'b1, (i % 2) == 0, 8'(i / 3), 8'(i));
        drain();
        check_eq("t6_delivered", n_deliv, 40);
        check_eq("t6_ovf", overflow, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
